// File: rtl/aes_pkg.sv
// Shared types, round-count helper and byte-level primitives for the iterative AES core.
// The S-box is the FIPS-197 forward substitution table. It is indexed by the input byte value.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

    typedef logic [127:0] aes_state_t;
    typedef logic [3:0]   aes_rnd_t;

    // Number of cipher rounds. Only 128 and 256 are legal; the top rejects other key sizes.
    function automatic int nr_of(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/Add_Round_Key.sv
// AddRoundKey: bitwise XOR of the state with the current round key.
module Add_Round_Key (
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    output logic [127:0] state_o
);

    assign state_o = state_i ^ round_key_i;

endmodule

// File: rtl/aes_round_comb.sv
// One full AES round as pure combinational logic; is_last_i drops MixColumns for the final round.
module aes_round_comb (
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         is_last_i,
    output logic [127:0] state_o
);

    logic [127:0] sb_out;
    logic [127:0] sr_out;
    logic [127:0] mc_out;
    logic [127:0] ark_in;

    sub_bytes u_sub_bytes (
        .state_i (state_i),
        .state_o (sb_out)
    );

    shift_row u_shift_row (
        .state_i (sb_out),
        .state_o (sr_out)
    );

    mix_columns u_mix_columns (
        .state_i (sr_out),
        .state_o (mc_out)
    );

    assign ark_in = is_last_i ? sr_out : mc_out;

    Add_Round_Key u_add_round_key (
        .state_i     (ark_in),
        .round_key_i (round_key_i),
        .state_o     (state_o)
    );

endmodule

// File: rtl/mix_columns.sv
// MixColumns: each column is multiplied by the fixed circulant matrix {02,03,01,01}.
module mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;

        assign a0 = state_i[127-32*c -: 8];
        assign a1 = state_i[119-32*c -: 8];
        assign a2 = state_i[111-32*c -: 8];
        assign a3 = state_i[103-32*c -: 8];

        // 3*a is written as xtime(a) ^ a.
        assign state_o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign state_o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign state_o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign state_o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/shift_row.sv
// ShiftRows: row r of the column-major state rotates left by r byte positions.
module shift_row (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);

    // Byte n = row + 4*col sits at bits [127-8n -: 8].
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign state_o[127-8*(r+4*c) -: 8] = state_i[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end

endmodule

// File: rtl/sub_bytes.sv
// SubBytes: independent S-box substitution of all 16 state bytes.
module sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign state_o[8*i +: 8] = SBOX[state_i[8*i +: 8]];
    end

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES encryption core: one shared round datapath, NR+1 cycles per block,
// valid/ready on both sides and round keys fetched by index from an external store.
module aes_iter_cipher
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt,
    output logic [3:0]   round_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct
);

    localparam aes_rnd_t NR = aes_rnd_t'(nr_of(KEY_BITS));

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_cipher: KEY_BITS must be 128 or 256, got %0d", KEY_BITS);
    end

    aes_fsm_e   fsm_q, fsm_d;
    aes_state_t state_q, state_d;
    aes_rnd_t   rnd_q, rnd_d;
    logic       out_valid_q;
    logic       accept;
    logic       is_last;
    aes_state_t round_out;

    assign is_last = (rnd_q == NR);

    aes_round_comb u_round (
        .state_i     (state_q),
        .round_key_i (round_key),
        .is_last_i   (is_last),
        .state_o     (round_out)
    );

    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        round_idx = '0;

        case (fsm_q)
            IDLE:    in_ready = 1'b1;
            RUN:     round_idx = rnd_q;
            DONE:    in_ready = out_ready;
            default: ;
        endcase

        accept = in_valid && in_ready;

        case (fsm_q)
            IDLE, DONE: begin
                if (accept) begin
                    // Round 0 is AddRoundKey alone; round_idx is 0 here, so round_key is key 0.
                    state_d = pt ^ round_key;
                    rnd_d   = aes_rnd_t'(1);
                    fsm_d   = RUN;
                end else if (fsm_q == DONE && out_ready) begin
                    fsm_d = IDLE;
                end
            end
            RUN: begin
                state_d = round_out;
                if (is_last) begin
                    fsm_d = DONE;
                end else begin
                    rnd_d = rnd_q + aes_rnd_t'(1);
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            out_valid_q <= (fsm_d == DONE);
        end
    end

    assign ct        = state_q;
    assign out_valid = out_valid_q;

    a_rnd_bounded: assert property (@(posedge clk) disable iff (rst) rnd_q <= NR);
    a_ct_held: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(ct)));

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Scoreboard bench for aes_iter_cipher: an AES-128 and an AES-256 instance, each with its own key-store model.
`timescale 1ns/1ps
module tb_aes_iter_cipher;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_C128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        in_valid;
    logic [1:0]        in_ready;
    logic [1:0]        out_valid;
    logic [1:0]        out_ready;
    logic [1:0][127:0] pt;
    logic [1:0][127:0] ct;
    logic [1:0][127:0] round_key;
    logic [1:0][127:0] exp_next;
    logic [1:0][3:0]   round_idx;

    logic [127:0] rk [2][16];
    logic [7:0]   tb_sbox [256];
    logic [127:0] sb0 [$];
    logic [127:0] sb1 [$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           xfer_cnt [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_iter_cipher #(.KEY_BITS(128)) u_dut128 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .pt        (pt[0]),
        .round_idx (round_idx[0]),
        .round_key (round_key[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .ct        (ct[0])
    );

    aes_iter_cipher #(.KEY_BITS(256)) u_dut256 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .pt        (pt[1]),
        .round_idx (round_idx[1]),
        .round_key (round_key[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .ct        (ct[1])
    );

    // Key store: serves the expanded key for whatever index the core requests, same cycle.
    assign round_key[0] = rk[0][round_idx[0]];
    assign round_key[1] = rk[1][round_idx[1]];

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

    // S-box derived from the field inverse plus affine map, independent of any lookup table.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            tb_sbox[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
    endfunction

    task automatic load_key(input int k, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        int          nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gf_xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) rk[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] p, input int k, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] x = p ^ rk[k][0];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = tb_sbox[x[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) t[j+4*c] = s[j+4*((c+j)%4)];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                    t[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) x[127-8*i -: 8] = t[i] ^ rk[k][r][127-8*i -: 8];
        end
        return x;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: push on accept, pop and compare on retire.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid[0] && in_ready[0]) sb0.push_back(exp_next[0]);
            if (in_valid[1] && in_ready[1]) sb1.push_back(exp_next[1]);
            if (out_valid[0] && out_ready[0]) begin
                xfer_cnt[0]++;
                if (sb0.size() == 0) check("spurious_out_128", 1, 0);
                else check("ct_128", ct[0], sb0.pop_front());
            end
            if (out_valid[1] && out_ready[1]) begin
                xfer_cnt[1]++;
                if (sb1.size() == 0) check("spurious_out_256", 1, 0);
                else check("ct_256", ct[1], sb1.pop_front());
            end
        end
    end

    // Holds in_valid until the core is ready, then returns just after the accept edge.
    task automatic wait_accept(input int k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[k] && n < 100);
        check("accept_ready", 128'(in_ready[k]), 1);
        @(posedge clk); #1;
    endtask

    task automatic run_block(input int k, input logic [127:0] p, input logic [127:0] e,
                             input int nr, input bit scramble);
        int j = 0;
        bit idx_ok = 1'b1;
        @(posedge clk); #1;
        pt[k] = p; exp_next[k] = e; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
        wait_accept(k);
        in_valid[k] = 1'b0;
        while (1) begin
            @(negedge clk);
            if (out_valid[k]) break;
            if (round_idx[k] != 4'(j + 1)) idx_ok = 1'b0;
            j++;
            if (j > 40) break;
            @(posedge clk); #1;
            if (scramble) pt[k] = rand128();
        end
        check("latency", 128'(j), 128'(nr));
        check("round_idx_seq", 128'(idx_ok), 1);
        @(posedge clk); #1;
    endtask

    task automatic back_to_back(input int k, input int nr, input int nblk);
        int last = 0;
        int n;
        @(posedge clk); #1;
        out_ready[k] = 1'b1; in_valid[k] = 1'b1;
        pt[k] = rand128(); exp_next[k] = aes_model(pt[k], k, nr);
        for (int b = 0; b < nblk; b++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready[k] && n < 40);
            check("b2b_accept", 128'(in_ready[k]), 1);
            if (b > 0) begin
                check("b2b_retire_same_cycle", 128'(out_valid[k]), 1);
                check("b2b_period", 128'(cyc - last), 128'(nr + 1));
            end
            last = cyc;
            @(posedge clk); #1;
            if (b < nblk - 1) begin
                pt[k] = rand128(); exp_next[k] = aes_model(pt[k], k, nr);
            end else begin
                in_valid[k] = 1'b0;
            end
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid[k] && n < 40);
        check("b2b_drain", 128'(out_valid[k]), 1);
        @(posedge clk); #1;
    endtask

    task automatic backpressure(input int k, input int nr);
        logic [127:0] held;
        bit stable_ok = 1'b1, ready_low = 1'b1, valid_high = 1'b1;
        int x0;
        int n = 0;
        @(posedge clk); #1;
        out_ready[k] = 1'b0; in_valid[k] = 1'b1;
        pt[k] = rand128(); exp_next[k] = aes_model(pt[k], k, nr);
        wait_accept(k);
        in_valid[k] = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid[k] && n < 40);
        check("bp_out_valid", 128'(out_valid[k]), 1);
        held = ct[k];
        x0 = xfer_cnt[k];
        @(posedge clk); #1;
        in_valid[k] = 1'b1; pt[k] = rand128(); exp_next[k] = ~128'h0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ct[k] !== held) stable_ok = 1'b0;
            if (in_ready[k] !== 1'b0) ready_low = 1'b0;
            if (out_valid[k] !== 1'b1) valid_high = 1'b0;
            @(posedge clk); #1;
            pt[k] = rand128();
        end
        check("bp_ct_stable", 128'(stable_ok), 1);
        check("bp_in_ready_low", 128'(ready_low), 1);
        check("bp_valid_held", 128'(valid_high), 1);
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_one_transfer", 128'(xfer_cnt[k] - x0), 1);
        check("bp_valid_dropped", 128'(out_valid[k]), 0);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_run(input int k, input int nr);
        int n = 0;
        int ov_seen = 0;
        @(posedge clk); #1;
        out_ready[k] = 1'b1; in_valid[k] = 1'b1;
        pt[k] = rand128(); exp_next[k] = aes_model(pt[k], k, nr);
        wait_accept(k);
        in_valid[k] = 1'b0;
        while (round_idx[k] != 4'd5 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_reached_round5", 128'(round_idx[k]), 5);
        rst = 1'b1;
        sb0.delete();
        sb1.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid[k]), 0);
        check("rst_ct", ct[k], 0);
        check("rst_round_idx", 128'(round_idx[k]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid[k]) ov_seen++;
        end
        check("rst_no_output", 128'(ov_seen), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = '0; out_ready = '0; pt = '0; exp_next = '0;
        xfer_cnt[0] = 0; xfer_cnt[1] = 0;
        build_sbox();
        load_key(0, KEY_B, 4);
        load_key(1, KEY_C256, 8);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_in_ready", 128'(in_ready[k]), 1);
            check("reset_out_valid", 128'(out_valid[k]), 0);
            check("reset_ct", ct[k], 0);
            check("reset_round_idx", 128'(round_idx[k]), 0);
        end

        run_block(0, PT_B, CT_B, 10, 1'b0);
        load_key(0, KEY_C128, 4);
        run_block(0, PT_C, CT_C1, 10, 1'b0);
        run_block(0, PT_C, CT_C1, 10, 1'b1);
        backpressure(0, 10);
        back_to_back(0, 10, 3);
        reset_mid_run(0, 10);
        run_block(0, PT_C, CT_C1, 10, 1'b0);

        run_block(1, PT_C, CT_C3, 14, 1'b0);
        back_to_back(1, 14, 3);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sb_empty_128", 128'(sb0.size()), 0);
        check("sb_empty_256", 128'(sb1.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
